// File: rtl/ts_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ts_pkg
//  Description : Shared constants and FSM state encodings for the TS ingress
//                packer (ts_pack) and its bank RAM.
//  Contents    : TS_SYNC, TS_PKT_WORDS, TS_HDR_WORDS, TS_BURST_WORDS,
//                in_state_t (HUNT/LOCK), out_state_t (IDLE/HDR0-2/PAY)
//  Revision    : 1.0 - initial release
// ============================================================================
package ts_pkg;

    localparam logic [7:0] TS_SYNC        = 8'h47;
    localparam int         TS_PKT_WORDS   = 47;
    localparam int         TS_HDR_WORDS   = 3;
    localparam int         TS_BURST_WORDS = 50;

    // Input side: searching for sync, or counting bytes of a locked stream.
    typedef enum logic [0:0] {
        IN_HUNT = 1'b0,
        IN_LOCK = 1'b1
    } in_state_t;

    // Output side: one burst is HDR0, HDR1, HDR2 then the payload words.
    typedef enum logic [2:0] {
        OUT_IDLE = 3'd0,
        OUT_HDR0 = 3'd1,
        OUT_HDR1 = 3'd2,
        OUT_HDR2 = 3'd3,
        OUT_PAY  = 3'd4
    } out_state_t;

endpackage
`default_nettype wire

// File: rtl/ts_pack_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ts_pack_bank_ram
//  Description : Two-bank simple dual-port RAM (2 x WORDS entries of 32 bits).
//                One write port, one read port with 1-cycle read latency.
//                Address MSB selects the bank, low bits select the word.
//  Ports       : clk              - clock
//                wr_en/wr_addr/wr_data - write port
//                rd_addr          - read address (registered into rd_data)
//                rd_data          - read data, valid the cycle after rd_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module ts_pack_bank_ram
    import ts_pkg::*;
#(
    parameter int WORDS = TS_PKT_WORDS,
    parameter int AW    = 6
)(
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW:0]   wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW:0]   rd_addr,
    output logic [31:0]   rd_data
);

    localparam int c_DEPTH = 2 * WORDS;
    localparam int c_IW    = $clog2(c_DEPTH);

    logic [31:0]     r_mem [0:c_DEPTH-1];
    logic [31:0]     r_rd_data;
    logic [c_IW-1:0] w_wr_idx;
    logic [c_IW-1:0] w_rd_idx;

    // Banks are packed back to back so the array holds exactly 2*WORDS
    // entries even though the bank bit sits at the address MSB.
    function automatic logic [c_IW-1:0] f_idx(input logic [AW:0] a);
        if (a[AW])
            f_idx = c_IW'(WORDS) + c_IW'(a[AW-1:0]);
        else
            f_idx = c_IW'(a[AW-1:0]);
    endfunction

    assign w_wr_idx = f_idx(wr_addr);
    assign w_rd_idx = f_idx(rd_addr);

    always_ff @(posedge clk) begin
        if (wr_en)
            r_mem[w_wr_idx] <= wr_data;
        r_rd_data <= r_mem[w_rd_idx];
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/ts_pack.sv
`default_nettype none
// ============================================================================
//  Module      : ts_pack
//  Description : MPEG-TS ingress packer. Locks onto the sync byte at packet
//                spacing, packs each complete packet big-endian into a
//                two-bank buffer and emits it as a contiguous burst of
//                3 header words + payload words on a 33-bit bus
//                (bit 32 = start-of-packet).
//  Ports       : clk, rst (async, active high)
//                ts_byte/ts_byte_en        - byte stream in (gaps allowed)
//                cfg_chan/cfg_ip/cfg_port  - header contents, captured per packet
//                ts_dout/ts_dout_en        - burst output, 0 when not valid
//                locked                    - sync acquired
//                pkt_cnt/sync_err_cnt      - only with TS_PACK_STAT_EN
//  Options     : `define TS_PACK_STAT_EN adds packet and sync-loss counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ts_pack
    import ts_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = TS_SYNC,
    parameter int         PKT_BYTES = 188
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ts_byte,
    input  logic        ts_byte_en,
    input  logic [31:0] cfg_chan,
    input  logic [31:0] cfg_ip,
    input  logic [15:0] cfg_port,
    output logic [32:0] ts_dout,
    output logic        ts_dout_en,
    output logic        locked
`ifdef TS_PACK_STAT_EN
    ,
    output logic [31:0] pkt_cnt,
    output logic [15:0] sync_err_cnt
`endif
);

    localparam int               c_BCW       = $clog2(PKT_BYTES);
    localparam int               c_WA        = c_BCW - 2;
    localparam int               c_PKT_WORDS = PKT_BYTES / 4;
    localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(PKT_BYTES - 1);
    localparam logic [c_WA-1:0]  c_LAST_WORD = c_WA'(c_PKT_WORDS - 1);

    // ---------------------------------------------------------------- input
    in_state_t          r_in_state;
    in_state_t          w_in_next;
    logic [c_BCW-1:0]   r_byte_cnt;
    logic [23:0]        r_shift;
    logic               r_wr_bank;
    logic               w_is_sync;
    logic               w_at_start;
    logic               w_accept;
    logic               w_bad_sync;
    logic               w_pkt_done;
    logic               w_wr_en;
    logic [c_WA:0]      w_wr_addr;
    logic [31:0]        w_wr_data;

    // Byte counter is 0 whenever HUNT is entered, so "accept" reduces to:
    // any byte mid-packet, or a sync byte at packet start.
    assign w_is_sync  = (ts_byte == SYNC_BYTE);
    assign w_at_start = (r_byte_cnt == '0);
    assign w_accept   = ts_byte_en && (!w_at_start || w_is_sync);
    assign w_bad_sync = ts_byte_en && w_at_start && !w_is_sync;
    assign w_pkt_done = w_accept && (r_byte_cnt == c_LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_in_state <= IN_HUNT;
        else
            r_in_state <= w_in_next;
    end

    always_comb begin
        w_in_next = r_in_state;
        if (r_in_state == IN_HUNT) begin
            if (w_accept)
                w_in_next = IN_LOCK;
        end else begin
            if (w_bad_sync)
                w_in_next = IN_HUNT;
        end
    end

    always_comb begin
        locked = (r_in_state == IN_LOCK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_wr_bank  <= 1'b0;
        end else if (w_accept) begin
            r_shift <= {r_shift[15:0], ts_byte};
            if (w_pkt_done) begin
                r_byte_cnt <= '0;
                r_wr_bank  <= ~r_wr_bank;
            end else begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
        end
    end

    // Fourth byte of each word completes it: the three older bytes are in
    // the shift register, the newest one is on the input.
    assign w_wr_en   = w_accept && (r_byte_cnt[1:0] == 2'b11);
    assign w_wr_addr = {r_wr_bank, r_byte_cnt[c_BCW-1:2]};
    assign w_wr_data = {r_shift, ts_byte};

    // Header captured per bank so a late cfg change never touches a burst.
    logic [31:0] r_hdr_chan [0:1];
    logic [31:0] r_hdr_ip   [0:1];
    logic [15:0] r_hdr_port [0:1];

    always_ff @(posedge clk) begin
        if (w_pkt_done) begin
            r_hdr_chan[r_wr_bank] <= cfg_chan;
            r_hdr_ip[r_wr_bank]   <= cfg_ip;
            r_hdr_port[r_wr_bank] <= cfg_port;
        end
    end

    // ------------------------------------------------------------ bank flags
    logic [1:0] r_full;
    logic [1:0] w_set;
    logic [1:0] w_clr;
    logic       w_pay_last;
    logic       r_rd_bank;

    assign w_set = w_pkt_done ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clr = w_pay_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_full <= 2'b00;
        else
            r_full <= (r_full & ~w_clr) | w_set;
    end

    // --------------------------------------------------------------- output
    out_state_t       r_out_state;
    out_state_t       w_out_next;
    logic [c_WA-1:0]  r_pay_cnt;
    logic [c_WA-1:0]  w_rd_word;
    logic [31:0]      w_rd_data;
    logic [32:0]      w_dout;
    logic             w_dout_en;
    logic [32:0]      r_dout;
    logic             r_dout_en;
    logic             w_other_bank;

    assign w_pay_last   = (r_out_state == OUT_PAY) && (r_pay_cnt == c_LAST_WORD);
    assign w_other_bank = ~r_rd_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_state <= OUT_IDLE;
            r_pay_cnt   <= '0;
            r_rd_bank   <= 1'b0;
        end else begin
            r_out_state <= w_out_next;
            if ((r_out_state == OUT_PAY) && !w_pay_last)
                r_pay_cnt <= r_pay_cnt + 1'b1;
            else
                r_pay_cnt <= '0;
            if (w_pay_last)
                r_rd_bank <= ~r_rd_bank;
        end
    end

    always_comb begin
        w_out_next = r_out_state;
        case (r_out_state)
            OUT_IDLE: if (r_full[r_rd_bank]) w_out_next = OUT_HDR0;
            OUT_HDR0: w_out_next = OUT_HDR1;
            OUT_HDR1: w_out_next = OUT_HDR2;
            OUT_HDR2: w_out_next = OUT_PAY;
            OUT_PAY:  if (w_pay_last)
                          w_out_next = r_full[w_other_bank] ? OUT_HDR0 : OUT_IDLE;
            default:  w_out_next = OUT_IDLE;
        endcase
    end

    // Read address runs one word ahead of the emitted word to cover the
    // RAM read latency: word 0 is addressed during HDR2.
    always_comb begin
        w_dout    = '0;
        w_dout_en = 1'b0;
        w_rd_word = '0;
        case (r_out_state)
            OUT_HDR0: begin
                w_dout_en = 1'b1;
                w_dout    = {1'b1, r_hdr_chan[r_rd_bank]};
            end
            OUT_HDR1: begin
                w_dout_en = 1'b1;
                w_dout    = {1'b0, r_hdr_ip[r_rd_bank]};
            end
            OUT_HDR2: begin
                w_dout_en = 1'b1;
                w_dout    = {1'b0, 16'h0000, r_hdr_port[r_rd_bank]};
            end
            OUT_PAY: begin
                w_dout_en = 1'b1;
                w_dout    = {1'b0, w_rd_data};
                if (r_pay_cnt != c_LAST_WORD)
                    w_rd_word = r_pay_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout    <= '0;
            r_dout_en <= 1'b0;
        end else begin
            r_dout    <= w_dout;
            r_dout_en <= w_dout_en;
        end
    end

    assign ts_dout    = r_dout;
    assign ts_dout_en = r_dout_en;

    ts_pack_bank_ram #(
        .WORDS (c_PKT_WORDS),
        .AW    (c_WA)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (w_wr_data),
        .rd_addr ({r_rd_bank, w_rd_word}),
        .rd_data (w_rd_data)
    );

`ifdef TS_PACK_STAT_EN
    // ---------------------------------------------------------- statistics
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_sync_err_cnt;
    logic        w_sync_lost;

    assign w_sync_lost = (r_in_state == IN_LOCK) && (w_in_next == IN_HUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt      <= '0;
            r_sync_err_cnt <= '0;
        end else begin
            if (r_out_state == OUT_HDR0)
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            if (w_sync_lost && (r_sync_err_cnt != 16'hFFFF))
                r_sync_err_cnt <= r_sync_err_cnt + 1'b1;
        end
    end

    assign pkt_cnt      = r_pkt_cnt;
    assign sync_err_cnt = r_sync_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ts_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ts_pack
//  Description : Self-checking bench for ts_pack. The stimulus side pushes the
//                expected burst words and start cycle into queues when a full
//                packet has been driven; a monitor on the falling edge pops
//                and compares whenever ts_dout_en is high.
//                Counter checks are compiled in with TS_PACK_STAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ts_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ts_byte = 8'h00;
    logic        ts_byte_en = 1'b0;
    logic [31:0] cfg_chan = 32'h0000_0001;
    logic [31:0] cfg_ip   = 32'hC012_0801;
    logic [15:0] cfg_port = 16'h0021;
    logic [32:0] ts_dout;
    logic        ts_dout_en;
    logic        locked;
`ifdef TS_PACK_STAT_EN
    logic [31:0] pkt_cnt;
    logic [15:0] sync_err_cnt;
    logic [31:0] pkt_base;
    logic [15:0] err_base;
`endif

    ts_pack dut (
        .clk        (clk),
        .rst        (rst),
        .ts_byte    (ts_byte),
        .ts_byte_en (ts_byte_en),
        .cfg_chan   (cfg_chan),
        .cfg_ip     (cfg_ip),
        .cfg_port   (cfg_port),
        .ts_dout    (ts_dout),
        .ts_dout_en (ts_dout_en),
        .locked     (locked)
`ifdef TS_PACK_STAT_EN
        ,
        .pkt_cnt      (pkt_cnt),
        .sync_err_cnt (sync_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] exp_q[$];
    int          start_q[$];
    logic [32:0] cap [0:49];
    int          widx  = 0;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (rst) begin
            widx = 0;
        end else if (ts_dout_en) begin
            if (ts_dout[32]) begin
                widx = 0;
                chk("burst_expected", 33'(start_q.size() != 0), 33'd1);
                if (start_q.size() != 0)
                    chk("hdr0_cycle", 33'(cyc), 33'(start_q.pop_front()));
            end
            if (exp_q.size() == 0)
                chk("word_expected", 33'd0, 33'd1);
            else
                chk($sformatf("word%0d", widx), ts_dout, exp_q.pop_front());
            if (widx < 50)
                cap[widx] = ts_dout;
            widx++;
        end else begin
            chk("idle_dout_zero", ts_dout, 33'd0);
            if (widx > 0 && widx < 50) begin
                chk("burst_gap", 33'(widx), 33'd50);
                widx = 0;
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    function automatic logic [7:0] pat(input int kind, input int n);
        logic [31:0] nn;
        nn = n;
        if (n == 0)
            return 8'h47;
        return (kind == 1) ? nn[7:0] : 8'h00;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input logic en);
        ts_byte    = b;
        ts_byte_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ts_byte_en = 1'b0;
        ts_byte    = 8'h00;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind 0: 0x47 then zeros; kind 1: byte n = n[7:0] with byte 0 = 0x47
    task automatic send_pkt(input int kind, input bit gaps, input int nbytes, input bit expect_out);
        logic [7:0] b [0:187];
        for (int n = 0; n < 188; n++)
            b[n] = pat(kind, n);
        for (int n = 0; n < nbytes; n++) begin
            if (gaps && n > 0)
                drive_byte(8'h47, 1'b0);
            drive_byte(b[n], 1'b1);
        end
        ts_byte_en = 1'b0;
        ts_byte    = 8'h00;
        if (expect_out) begin
            start_q.push_back(cyc + 2);
            exp_q.push_back({1'b1, cfg_chan});
            exp_q.push_back({1'b0, cfg_ip});
            exp_q.push_back({1'b0, 16'h0000, cfg_port});
            for (int k = 0; k < 47; k++)
                exp_q.push_back({1'b0, b[4*k], b[4*k+1], b[4*k+2], b[4*k+3]});
        end
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || start_q.size() != 0) && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(name, 33'(exp_q.size() + start_q.size()), 33'd0);
        idle(3);
    endtask

    task automatic pulse_reset(input string name);
        rst = 1'b1;
        exp_q.delete();
        start_q.delete();
        #1;
        chk({name, "_dout"},   ts_dout, 33'd0);
        chk({name, "_en"},     33'(ts_dout_en), 33'd0);
        chk({name, "_locked"}, 33'(locked), 33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout",   ts_dout, 33'd0);
        chk("reset_en",     33'(ts_dout_en), 33'd0);
        chk("reset_locked", 33'(locked), 33'd0);
        rst = 1'b0;
        idle(2);

        // single all-zero packet
        send_pkt(0, 1'b0, 188, 1'b1);
        wait_drain("drain_single");
        chk("single_w0",  cap[0],  33'h1_0000_0001);
        chk("single_w1",  cap[1],  33'h0_C012_0801);
        chk("single_w2",  cap[2],  33'h0_0000_0021);
        chk("single_w3",  cap[3],  33'h0_4700_0000);
        chk("single_w49", cap[49], 33'h0_0000_0000);

        // counting pattern; cfg changed mid-burst must not leak in
        send_pkt(1, 1'b0, 188, 1'b1);
        idle(10);
        cfg_chan = 32'h0000_00AA;
        cfg_ip   = 32'h0A00_0001;
        cfg_port = 16'h1234;
        wait_drain("drain_pattern");
        chk("pattern_w0",  cap[0],  33'h1_0000_0001);
        chk("pattern_w2",  cap[2],  33'h0_0000_0021);
        chk("pattern_w3",  cap[3],  33'h0_4701_0203);
        chk("pattern_w49", cap[49], 33'h0_B8B9_BABB);
        cfg_chan = 32'h0000_0001;
        cfg_ip   = 32'hC012_0801;
        cfg_port = 16'h0021;

        // two back-to-back packets then a bad sync byte
`ifdef TS_PACK_STAT_EN
        pkt_base = pkt_cnt;
        err_base = sync_err_cnt;
`endif
        send_pkt(1, 1'b0, 188, 1'b1);
        send_pkt(0, 1'b0, 188, 1'b1);
        chk("locked_before_bad", 33'(locked), 33'd1);
        drive_byte(8'h00, 1'b1);
        chk("locked_after_bad", 33'(locked), 33'd0);
        for (int n = 1; n < 188; n++)
            drive_byte(8'h00, 1'b1);
        idle(60);
        chk("still_hunting", 33'(locked), 33'd0);
        wait_drain("drain_b2b");
`ifdef TS_PACK_STAT_EN
        chk("pkt_cnt_delta",      33'(pkt_cnt - pkt_base), 33'd2);
        chk("sync_err_cnt_delta", 33'(sync_err_cnt - err_base), 33'd1);
`endif

        // garbage then a valid packet
        for (int n = 0; n < 10; n++)
            drive_byte(8'h00, 1'b1);
        chk("garbage_unlocked", 33'(locked), 33'd0);
        send_pkt(1, 1'b0, 188, 1'b1);
        wait_drain("drain_garbage");
        chk("garbage_w3", cap[3], 33'h0_4701_0203);

        // byte enable toggling every other cycle
        send_pkt(1, 1'b1, 188, 1'b1);
        wait_drain("drain_gaps");
        chk("gaps_w3",  cap[3],  33'h0_4701_0203);
        chk("gaps_w49", cap[49], 33'h0_B8B9_BABB);

        // reset after 100 bytes of a packet
        send_pkt(0, 1'b0, 100, 1'b0);
        chk("locked_partial", 33'(locked), 33'd1);
        pulse_reset("rst_partial");
        idle(60);
        send_pkt(0, 1'b0, 188, 1'b1);
        wait_drain("drain_after_rst");
        chk("after_rst_w0", cap[0], 33'h1_0000_0001);
        chk("after_rst_w3", cap[3], 33'h0_4700_0000);

        // reset in the middle of a burst
        send_pkt(1, 1'b0, 188, 1'b1);
        send_pkt(0, 1'b0, 20, 1'b0);
        chk("en_before_midrst", 33'(ts_dout_en), 33'd1);
        pulse_reset("rst_midburst");
`ifdef TS_PACK_STAT_EN
        chk("pkt_cnt_after_rst", 33'(pkt_cnt), 33'd0);
`endif
        idle(100);
        send_pkt(1, 1'b0, 188, 1'b1);
        wait_drain("drain_final");
        chk("final_w49", cap[49], 33'h0_B8B9_BABB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
